// File: rtl/pkt_tx.sv
// Credit-flow-controlled packet transmitter feeding one switch input link.
// Define PKT_TX_CNT_EN to add the 16-bit tx_cnt packet counter port.
module pkt_tx #(
    parameter int DATAW   = 16,
    parameter int DSTW    = 2,
    parameter int SRCW    = 2,
    parameter int SRC_ID  = 0,
    parameter int DEPTH   = 4,
    parameter int CREDITS = 4,
    parameter int GAP     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DSTW-1:0]                in_dst,
    input  logic [DATAW-1:0]               in_data,
    output logic                           in_ready,
    input  logic                           credit,
    output logic [DATAW+DSTW+SRCW:0]       o,
    output logic                           busy,
    output logic                           cr_err
`ifdef PKT_TX_CNT_EN
    ,
    output logic [15:0]                    tx_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int OW = DATAW + DSTW + SRCW + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [3:0]    GAP_L    = 4'(GAP);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    logic [DSTW+DATAW-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [CW-1:0]         r_cred;
    logic [3:0]            r_gap;
    logic [OW-1:0]         r_o;
    logic                  r_cr_err;
    state_t                r_state;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_can_send;
    logic                  w_send;
    logic [DSTW+DATAW-1:0] w_head;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal).
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push     = in_valid && !w_full;
    assign w_can_send = !w_empty && (r_cred != '0);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: always_comb assigns a default first so no path leaves w_send unassigned (no latch).
    always_comb begin
        w_send = 1'b0;
        case (r_state)
            IDLE:    w_send = w_can_send;
            SEND:    w_send = (GAP == 0) && w_can_send;
            WAIT:    w_send = (r_gap == 4'd1) && w_can_send;
            default: w_send = 1'b0;
        endcase
    end

    // NOTE: the storage array has no reset; validity is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_dst, in_data};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_send) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_o     <= '0;
            r_gap   <= '0;
        end else begin
            r_o <= '0;
            if (w_send) begin
                r_o <= {1'b1, w_head[DSTW+DATAW-1:DATAW], SRCW'(SRC_ID), w_head[DATAW-1:0]};
            end
            case (r_state)
                IDLE: begin
                    if (w_send) r_state <= SEND;
                end
                SEND: begin
                    if (GAP == 0) begin
                        r_state <= w_send ? SEND : IDLE;
                    end else begin
                        r_gap   <= GAP_L;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Last idle cycle doubles as the IDLE decision, giving exactly GAP empty slots.
                    if (r_gap == 4'd1) begin
                        r_state <= w_send ? SEND : IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cred   <= CRED_MAX;
            r_cr_err <= 1'b0;
        end else begin
            case ({credit, w_send})
                2'b10: begin
                    if (r_cred == CRED_MAX) r_cr_err <= 1'b1;
                    else                    r_cred   <= r_cred + 1'b1;
                end
                2'b01:   r_cred <= r_cred - 1'b1;
                default: r_cred <= r_cred;
            endcase
        end
    end

`ifdef PKT_TX_CNT_EN
    logic [15:0] r_tx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_tx_cnt <= '0;
        else if (w_send) r_tx_cnt <= r_tx_cnt + 16'd1;
    end

    assign tx_cnt = r_tx_cnt;
`endif

    assign o        = r_o;
    assign in_ready = !w_full;
    assign busy     = !w_empty || (r_state != IDLE);
    assign cr_err   = r_cr_err;

endmodule

// File: tb/tb_pkt_tx.sv
// Bench for pkt_tx: two instances (GAP=0 and GAP=3) share stimulus, each checked
// every cycle against a timing-rule model of queue, credits and send spacing.
module tb_pkt_tx;

    localparam int DATAW   = 16;
    localparam int DSTW    = 2;
    localparam int SRCW    = 2;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 4;
    localparam int OW      = 1 + DSTW + SRCW + DATAW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DSTW-1:0]   in_dst = '0;
    logic [DATAW-1:0]  in_data = '0;
    logic              credit = 1'b0;

    logic [OW-1:0]     o0, o1;
    logic              rdy0, rdy1, busy0, busy1, err0, err1;
`ifdef PKT_TX_CNT_EN
    logic [15:0]       cnt0, cnt1;
    int                mtx [2];
`endif

    pkt_tx #(.DATAW(DATAW), .DSTW(DSTW), .SRCW(SRCW), .SRC_ID(1),
             .DEPTH(DEPTH), .CREDITS(CREDITS), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst), .in_data(in_data),
        .in_ready(rdy0), .credit(credit), .o(o0), .busy(busy0), .cr_err(err0)
`ifdef PKT_TX_CNT_EN
        , .tx_cnt(cnt0)
`endif
    );

    pkt_tx #(.DATAW(DATAW), .DSTW(DSTW), .SRCW(SRCW), .SRC_ID(2),
             .DEPTH(DEPTH), .CREDITS(CREDITS), .GAP(3)) u_gap3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst(in_dst), .in_data(in_data),
        .in_ready(rdy1), .credit(credit), .o(o1), .busy(busy1), .cr_err(err1)
`ifdef PKT_TX_CNT_EN
        , .tx_cnt(cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a bounded word buffer, a credit count and an earliest-next-send cycle.
    logic [DSTW+DATAW-1:0] mbuf [2][DEPTH];
    int                    mhead [2];
    int                    mcnt  [2];
    int                    mcred [2];
    int                    mnext [2];
    bit                    merr  [2];
    logic [OW-1:0]         mo    [2];
    int                    cyc;

    int checks = 0;
    int errors = 0;
    int sent0, sent1;
    int last1;
    bit gap_track;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0;
            mcnt[k]  = 0;
            mcred[k] = CREDITS;
            mnext[k] = 0;
            merr[k]  = 1'b0;
            mo[k]    = '0;
`ifdef PKT_TX_CNT_EN
            mtx[k]   = 0;
`endif
        end
        sent0 = 0;
        sent1 = 0;
    endtask

    task automatic model_edge();
        logic [DSTW+DATAW-1:0] w;
        int  cnt_before, cred_before;
        bit  snd;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            cnt_before  = mcnt[k];
            cred_before = mcred[k];
            snd = (cnt_before > 0) && (cred_before > 0) && (cyc >= mnext[k]);
            mo[k] = '0;
            if (snd) begin
                w        = mbuf[k][mhead[k]];
                mo[k]    = {1'b1, w[DSTW+DATAW-1:DATAW], 2'(k + 1), w[DATAW-1:0]};
                mhead[k] = (mhead[k] + 1) % DEPTH;
                mcnt[k]  = mcnt[k] - 1;
                mnext[k] = cyc + gap_of(k) + 1;
`ifdef PKT_TX_CNT_EN
                mtx[k]   = (mtx[k] + 1) % 65536;
`endif
            end
            if (in_valid && cnt_before < DEPTH) begin
                mbuf[k][(mhead[k] + mcnt[k]) % DEPTH] = {in_dst, in_data};
                mcnt[k] = mcnt[k] + 1;
            end
            if (credit && !snd && cred_before == CREDITS) merr[k] = 1'b1;
            else mcred[k] = cred_before - int'(snd) + int'(credit);
        end
    endtask

    task automatic compare(input string ph);
        check({ph, ".o0"},    32'(o0),    32'(mo[0]));
        check({ph, ".o1"},    32'(o1),    32'(mo[1]));
        check({ph, ".rdy0"},  32'(rdy0),  32'(mcnt[0] < DEPTH));
        check({ph, ".rdy1"},  32'(rdy1),  32'(mcnt[1] < DEPTH));
        check({ph, ".busy0"}, 32'(busy0), 32'((mcnt[0] > 0) || (cyc < mnext[0])));
        check({ph, ".busy1"}, 32'(busy1), 32'((mcnt[1] > 0) || (cyc < mnext[1])));
        check({ph, ".err0"},  32'(err0),  32'(merr[0]));
        check({ph, ".err1"},  32'(err1),  32'(merr[1]));
`ifdef PKT_TX_CNT_EN
        check({ph, ".cnt0"},  32'(cnt0),  32'(mtx[0]));
        check({ph, ".cnt1"},  32'(cnt1),  32'(mtx[1]));
`endif
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        if (o0[OW-1]) sent0++;
        if (o1[OW-1]) begin
            if (gap_track && last1 >= 0) check("gap3_spacing", 32'(cyc - last1), 32'd4);
            last1 = cyc;
            sent1++;
        end
        compare(ph);
    endtask

    task automatic idle(input string ph, input int n);
        repeat (n) tick(ph);
    endtask

    task automatic push(input string ph, input logic [DSTW-1:0] d, input logic [DATAW-1:0] v);
        in_valid = 1'b1;
        in_dst   = d;
        in_data  = v;
        tick(ph);
        in_valid = 1'b0;
    endtask

    task automatic push_rand(input string ph, input int n);
        for (int i = 0; i < n; i++) push(ph, 2'($urandom_range(0, 3)), 16'($urandom));
    endtask

    task automatic credit_pulse(input string ph);
        credit = 1'b1;
        tick(ph);
        credit = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset(input string ph);
        in_valid = 1'b0;
        credit   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare(ph);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        cyc       = 0;
        last1     = -1;
        gap_track = 1'b0;
        #1;
        model_reset();
        compare("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single packet: one-cycle latency, exact link word, then idle.
        do_reset("s1_rst");
        push("s1", 2'd2, 16'hA5A5);
        tick("s1");
        check("s1_word", 32'(o0), 32'({1'b1, 2'd2, 2'd1, 16'hA5A5}));
        tick("s1");
        check("s1_idle", 32'(o0), 32'd0);
        idle("s1", 4);

        // Six words, four credits: four go, then the rest after two credit pulses.
        do_reset("s2_rst");
        push_rand("s2", 6);
        idle("s2", 16);
        check("s2_sent0_first", 32'(sent0), 32'd4);
        check("s2_sent1_first", 32'(sent1), 32'd4);
        credit_pulse("s2");
        idle("s2", 3);
        credit_pulse("s2");
        idle("s2", 12);
        check("s2_sent0_total", 32'(sent0), 32'd6);

        // Gap spacing with plentiful credits.
        do_reset("s3_rst");
        last1     = -1;
        gap_track = 1'b1;
        push_rand("s3", 3);
        idle("s3", 14);
        gap_track = 1'b0;
        check("s3_sent1", 32'(sent1), 32'd3);

        // Credits exhausted: FIFO fills, extra push dropped, drains in order on credit return.
        do_reset("s4_rst");
        push_rand("s4", 4);
        idle("s4", 16);
        sent0 = 0;
        push_rand("s4", 5);
        check("s4_full_rdy0", 32'(rdy0), 32'd0);
        check("s4_full_rdy1", 32'(rdy1), 32'd0);
        idle("s4", 3);
        for (int i = 0; i < CREDITS; i++) credit_pulse("s4");
        idle("s4", 20);
        check("s4_drained0", 32'(sent0), 32'(DEPTH));

        // Credit overflow: sticky error, counter stays at maximum.
        do_reset("s5_rst");
        credit_pulse("s5");
        check("s5_err0", 32'(err0), 32'd1);
        idle("s5", 3);
        check("s5_err0_sticky", 32'(err0), 32'd1);
        push_rand("s5", 5);
        idle("s5", 25);
        check("s5_sent0", 32'(sent0), 32'd4);

        // Randomized traffic.
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_dst   = 2'($urandom_range(0, 3));
            in_data  = 16'($urandom);
            credit   = ($urandom_range(0, 3) == 0);
            tick("rnd");
        end
        in_valid = 1'b0;
        credit   = 1'b0;
        idle("rnd", 20);

        // Reset mid-stream with queued words and the GAP instance waiting.
        do_reset("s6_pre");
        push_rand("s6", 5);
        idle("s6", 2);
        do_reset("s6_rst");
        check("s6_o1",    32'(o1),    32'd0);
        check("s6_busy1", 32'(busy1), 32'd0);
        check("s6_rdy1",  32'(rdy1),  32'd1);
        idle("s6", 8);
        check("s6_no_more", 32'(sent0 + sent1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
